// File: rtl/mux_tree_pipe.sv
// Wide binary-select multiplexer built as a radix-2 tree, with optional pipeline
// registers every REG_EVERY levels; a valid bit and the unconsumed select travel alongside.
module mux_tree_pipe #(
   parameter int unsigned WIDTH     = 1,
   parameter int unsigned NUM_IN    = 8,
   parameter int unsigned REG_EVERY = 1,
   localparam int unsigned SELW     = $clog2(NUM_IN)
) (
   input  logic                    C,
   input  logic                    CLR,
   input  logic                    CE,
   input  logic                    VI,
   input  logic [SELW-1:0]         S,
   input  logic [NUM_IN*WIDTH-1:0] I,
   output logic [WIDTH-1:0]        O,
   output logic                    VO
);

   localparam int unsigned LEVELS = SELW;
   localparam int unsigned NPAD   = 1 << LEVELS;
   localparam int unsigned RE     = (REG_EVERY == 0) ? 1 : REG_EVERY;

   // g_lvl[k] holds the node values after k levels have been resolved;
   // g_lvl[k].g_sel.s carries select bits S[LEVELS-1:k] still to be consumed.
   genvar k;
   for (k = 0; k <= LEVELS; k++) begin : g_lvl
      localparam int unsigned NN  = NPAD >> k;
      localparam bit          REG = (k != 0) && (REG_EVERY != 0) &&
                                    (((k % RE) == 0) || (k == LEVELS));

      logic [NN*WIDTH-1:0] d;
      logic                v;

      if (k == 0) begin : g_leaf
         // leaves past NUM_IN read as zero so out-of-range selects give O = 0
         always_comb begin
            d = '0;
            for (int unsigned n = 0; n < NUM_IN; n++) begin
               d[n*WIDTH +: WIDTH] = I[n*WIDTH +: WIDTH];
            end
         end
         assign v = VI;
      end else begin : g_node
         logic [NN*WIDTH-1:0] mx;

         always_comb begin
            mx = '0;
            for (int unsigned j = 0; j < NN; j++) begin
               mx[j*WIDTH +: WIDTH] = g_lvl[k-1].g_sel.s[0]
                                    ? g_lvl[k-1].d[(2*j+1)*WIDTH +: WIDTH]
                                    : g_lvl[k-1].d[(2*j)*WIDTH +: WIDTH];
            end
         end

         if (REG) begin : g_reg
            always_ff @(posedge C or posedge CLR) begin
               if (CLR) begin
                  d <= '0;
                  v <= 1'b0;
               end else if (CE) begin
                  d <= mx;
                  v <= g_lvl[k-1].v;
               end
            end
         end else begin : g_comb
            assign d = mx;
            assign v = g_lvl[k-1].v;
         end
      end

      if (k < LEVELS) begin : g_sel
         logic [LEVELS-k-1:0] s;

         if (k == 0) begin : g_in
            assign s = S;
         end else if (REG) begin : g_reg
            always_ff @(posedge C or posedge CLR) begin
               if (CLR) begin
                  s <= '0;
               end else if (CE) begin
                  s <= g_lvl[k-1].g_sel.s[LEVELS-k:1];
               end
            end
         end else begin : g_comb
            assign s = g_lvl[k-1].g_sel.s[LEVELS-k:1];
         end
      end
   end

   assign O  = g_lvl[LEVELS].d;
   assign VO = g_lvl[LEVELS].v;

   if (REG_EVERY == 0) begin : g_no_clk
      logic unused_ctrl;
      assign unused_ctrl = C ^ CLR ^ CE;
   end

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Directed bench for mux_tree_pipe: three instances cover the pipelined 8-input,
// the 5-input two-levels-per-stage and the fully combinational configurations.
module tb_mux_tree_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // A: WIDTH=8, NUM_IN=8, REG_EVERY=1 -> LAT=3
   logic        clr_a, ce_a, vi_a, vo_a;
   logic [2:0]  s_a;
   logic [63:0] i_a;
   logic [7:0]  o_a;

   mux_tree_pipe #(.WIDTH(8), .NUM_IN(8), .REG_EVERY(1)) dut_a (
      .C(clk), .CLR(clr_a), .CE(ce_a), .VI(vi_a), .S(s_a), .I(i_a), .O(o_a), .VO(vo_a)
   );

   // B: WIDTH=8, NUM_IN=5, REG_EVERY=2 -> LAT=2
   logic        clr_b, ce_b, vi_b, vo_b;
   logic [2:0]  s_b;
   logic [39:0] i_b;
   logic [7:0]  o_b;

   mux_tree_pipe #(.WIDTH(8), .NUM_IN(5), .REG_EVERY(2)) dut_b (
      .C(clk), .CLR(clr_b), .CE(ce_b), .VI(vi_b), .S(s_b), .I(i_b), .O(o_b), .VO(vo_b)
   );

   // C: WIDTH=8, NUM_IN=6, REG_EVERY=0 -> combinational, clock held low
   logic        clk_c, clr_c, ce_c, vi_c, vo_c;
   logic [2:0]  s_c;
   logic [47:0] i_c;
   logic [7:0]  o_c;

   mux_tree_pipe #(.WIDTH(8), .NUM_IN(6), .REG_EVERY(0)) dut_c (
      .C(clk_c), .CLR(clr_c), .CE(ce_c), .VI(vi_c), .S(s_c), .I(i_c), .O(o_c), .VO(vo_c)
   );

   // CE pattern 1,0,0,1,1 lands on edges 3..7 of the stalled stream
   logic ce_tab4 [1:13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
   int   exp_v4  [1:13] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
   int   exp_o4  [1:13] = '{0, 0, 'h10, 'h10, 'h10, 'h11, 'h12, 'h13, 'h14, 'h15, 'h16, 'h17, 0};

   logic [2:0] s_tab3 [1:5] = '{3'd4, 3'd6, 3'd3, 3'd0, 3'd0};
   logic       v_tab3 [1:5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   int         exp_v3 [1:5] = '{0, 1, 1, 1, 0};
   int         exp_o3 [1:5] = '{0, 'hA4, 'h00, 'hA3, 0};

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int k;
      for (int n = 0; n < 8; n++) i_a[n*8 +: 8] = 8'(8'h10 + n);
      for (int n = 0; n < 5; n++) i_b[n*8 +: 8] = 8'(8'hA0 + n);
      for (int n = 0; n < 6; n++) i_c[n*8 +: 8] = 8'(8'h30 + n);
      clr_a = 1'b1; ce_a = 1'b1; vi_a = 1'b1; s_a = 3'd5;
      clr_b = 1'b1; ce_b = 1'b1; vi_b = 1'b0; s_b = 3'd0;
      clk_c = 1'b0; clr_c = 1'b0; ce_c = 1'b0; vi_c = 1'b0; s_c = 3'd0;

      // reset state, and reset holding through an edge with CE=1, VI=1
      #1;
      check("rst_o", o_a, 0);
      check("rst_vo", vo_a, 0);
      tick();
      check("rst_hold_vo", vo_a, 0);
      check("rst_b_vo", vo_b, 0);
      #2;
      clr_a = 1'b0; clr_b = 1'b0; vi_a = 1'b0;
      repeat (3) tick();

      // single transaction, S=5
      s_a = 3'd5; vi_a = 1'b1;
      tick();
      vi_a = 1'b0;
      check("t1_vo_e1", vo_a, 0);
      tick();
      check("t1_vo_e2", vo_a, 0);
      tick();
      check("t1_vo_e3", vo_a, 1);
      check("t1_o_e3", o_a, 'h15);
      tick();
      check("t1_vo_e4", vo_a, 0);

      // back-to-back stream S=0..7
      for (int e = 1; e <= 11; e++) begin
         if (e <= 8) begin
            s_a = 3'(e - 1); vi_a = 1'b1;
         end else begin
            vi_a = 1'b0;
         end
         tick();
         if (e >= 3 && e <= 10) begin
            check($sformatf("t2_vo_e%0d", e), vo_a, 1);
            check($sformatf("t2_o_e%0d", e), o_a, 32'(8'h10 + e - 3));
         end else begin
            check($sformatf("t2_vo_e%0d", e), vo_a, 0);
         end
      end

      // stream with stalls; source holds its item until a CE edge takes it
      k = 0;
      for (int e = 1; e <= 13; e++) begin
         ce_a = ce_tab4[e];
         s_a  = k[2:0];
         vi_a = (k < 8);
         tick();
         check($sformatf("t4_vo_e%0d", e), vo_a, exp_v4[e]);
         if (exp_v4[e] != 0) check($sformatf("t4_o_e%0d", e), o_a, exp_o4[e]);
         if (ce_tab4[e]) k++;
      end
      ce_a = 1'b1;

      // asynchronous clear mid-stream, then restart
      s_a = 3'd7; vi_a = 1'b1;
      repeat (3) tick();
      check("t5_pre_o", o_a, 'h17);
      check("t5_pre_vo", vo_a, 1);
      #2;
      clr_a = 1'b1;
      #1;
      check("t5_clr_o", o_a, 0);
      check("t5_clr_vo", vo_a, 0);
      tick();
      check("t5_clr_edge_vo", vo_a, 0);
      #2;
      clr_a = 1'b0; s_a = 3'd2; vi_a = 1'b1;
      tick();
      vi_a = 1'b0; s_a = 3'd0;
      check("t5_vo_e1", vo_a, 0);
      tick();
      check("t5_vo_e2", vo_a, 0);
      tick();
      check("t5_vo_e3", vo_a, 1);
      check("t5_o_e3", o_a, 'h12);

      // NUM_IN=5, two levels per stage, out-of-range select
      for (int e = 1; e <= 5; e++) begin
         s_b  = s_tab3[e];
         vi_b = v_tab3[e];
         tick();
         check($sformatf("t3_vo_e%0d", e), vo_b, exp_v3[e]);
         if (exp_v3[e] != 0) check($sformatf("t3_o_e%0d", e), o_b, exp_o3[e]);
      end

      // combinational configuration, no clock on C
      s_c = 3'd3; #1; check("t6_o_s3", o_c, 'h33);
      s_c = 3'd5; #1; check("t6_o_s5", o_c, 'h35);
      s_c = 3'd6; #1; check("t6_o_s6", o_c, 'h00);
      s_c = 3'd0; #1; check("t6_o_s0", o_c, 'h30);
      vi_c = 1'b1; #1; check("t6_vo_1", vo_c, 1);
      vi_c = 1'b0; #1; check("t6_vo_0", vo_c, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
